// File: rtl/sl_transmitter.sv
// Serial Line word transmitter: takes one word over valid/ready and emits it as
// low pulses on SL0 (bit 0) or SL1 (bit 1), LSB first, with optional odd parity.
module sl_transmitter #(
  parameter int PULSE_CYCLES    = 16,
  parameter int BIT_GAP_CYCLES  = 16,
  parameter int WORD_GAP_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tx_data,
  input  logic [5:0]  tx_bq,
  input  logic        tx_pce,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        sl0_o,
  output logic        sl1_o,
  output logic        busy,
  output logic        done,
  output logic        bq_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] WGAP = 2'd3;

  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(BIT_GAP_CYCLES - 1);
  localparam logic [15:0] WGAP_LAST  = 16'(WORD_GAP_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [32:0] frame_q, frame_d;
  logic [5:0]  total_q, total_d;
  logic [5:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sl0_q, sl0_d;
  logic        sl1_q, sl1_d;
  logic        done_q, done_d;
  logic        bqErr_q, bqErr_d;

  // Frame assembled at accept: data masked to N bits, parity bit placed at position N.
  logic [32:0] dataMask;
  logic [32:0] maskedData;
  logic [32:0] newFrame;
  logic        bqIllegal;

  always_comb begin
    dataMask   = (33'd1 << tx_bq) - 33'd1;
    maskedData = {1'b0, tx_data} & dataMask;
    newFrame   = maskedData | ((tx_pce && !(^maskedData)) ? (33'd1 << tx_bq) : 33'd0);
    bqIllegal  = (tx_bq == 6'd0) || (tx_bq > 6'd32);
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    total_d = total_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sl0_d   = sl0_q;
    sl1_d   = sl1_q;
    done_d  = 1'b0;
    bqErr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          if (bqIllegal) begin
            bqErr_d = 1'b1;
          end else begin
            frame_d = newFrame;
            total_d = tx_bq + {5'd0, tx_pce};
            idx_d   = 6'd0;
            cnt_d   = 16'd0;
            state_d = LOW;
            sl0_d   = newFrame[0];
            sl1_d   = ~newFrame[0];
          end
        end
      end
      LOW: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = 16'd0;
          state_d = HIGH;
          sl0_d   = 1'b1;
          sl1_d   = 1'b1;
          frame_d = frame_q >> 1;
          idx_d   = idx_q + 6'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HIGH: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 16'd0;
          if (idx_q == total_q) begin
            state_d = WGAP;
          end else begin
            state_d = LOW;
            sl0_d   = frame_q[0];
            sl1_d   = ~frame_q[0];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        if (cnt_q == WGAP_LAST) begin
          cnt_d   = 16'd0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= 33'd0;
      total_q <= 6'd0;
      idx_q   <= 6'd0;
      cnt_q   <= 16'd0;
      sl0_q   <= 1'b1;
      sl1_q   <= 1'b1;
      done_q  <= 1'b0;
      bqErr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      total_q <= total_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sl0_q   <= sl0_d;
      sl1_q   <= sl1_d;
      done_q  <= done_d;
      bqErr_q <= bqErr_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign sl0_o    = sl0_q;
  assign sl1_o    = sl1_q;
  assign done     = done_q;
  assign bq_err   = bqErr_q;

endmodule

// File: tb/tb_sl_transmitter.sv
// Directed bench for sl_transmitter: table of words with hand-computed frames,
// plus back-to-back, mid-word reset and reset-with-valid sequences.
module tb_sl_transmitter;

  localparam int P = 16;
  localparam int G = 16;
  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tx_data;
  logic [5:0]  tx_bq;
  logic        tx_pce;
  logic        tx_valid;
  logic        tx_ready;
  logic        sl0_o;
  logic        sl1_o;
  logic        busy;
  logic        done;
  logic        bq_err;

  int checks = 0;
  int failures = 0;
  int overlapCycles = 0;
  int doneErrCycles = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [5:0]  bq;
    logic        pce;
    logic [32:0] frame;
    int          nbits;
    bit          isErr;
  } vec_t;

  vec_t vecs[8];

  sl_transmitter #(
    .PULSE_CYCLES(P),
    .BIT_GAP_CYCLES(G),
    .WORD_GAP_CYCLES(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_bq(tx_bq),
    .tx_pce(tx_pce),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .sl0_o(sl0_o),
    .sl1_o(sl1_o),
    .busy(busy),
    .done(done),
    .bq_err(bq_err)
  );

  always #5 clk = ~clk;

  // Global invariants watched every cycle for the whole run.
  always @(negedge clk) begin
    if (sl0_o === 1'b0 && sl1_o === 1'b0) overlapCycles++;
    if (done === 1'b1 && bq_err === 1'b1) doneErrCycles++;
  end

  function automatic vec_t mkVec(input string name, input logic [31:0] data, input logic [5:0] bq,
                                 input logic pce, input logic [32:0] frame, input int nbits,
                                 input bit isErr);
    vec_t v;
    v.name = name; v.data = data; v.bq = bq; v.pce = pce;
    v.frame = frame; v.nbits = nbits; v.isErr = isErr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one word at a negedge; the accept edge is the following posedge.
  task automatic applyStimulus(input vec_t v, input bit keepValid);
    @(negedge clk);
    tx_data  = v.data;
    tx_bq    = v.bq;
    tx_pce   = v.pce;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keepValid) begin
      tx_valid = 1'b0;
      tx_data  = ~v.data;
      tx_bq    = 6'd5;
      tx_pce   = ~v.pce;
    end
  endtask

  // Checks cycles k+1 .. k+1+D against the expected pulse train of a frame.
  task automatic watchWord(input string name, input logic [32:0] frame, input int nb);
    int d;
    int badLine;
    int badBusy;
    int badPulse;
    int j;
    int pos;
    logic e0;
    logic e1;
    d = nb * (P + G) + W;
    badLine = 0;
    badBusy = 0;
    badPulse = 0;
    for (int c = 1; c <= d + 1; c++) begin
      @(negedge clk);
      if (c <= d) begin
        j = (c - 1) / (P + G);
        pos = (c - 1) % (P + G);
        e0 = 1'b1;
        e1 = 1'b1;
        if (j < nb && pos < P) begin
          if (frame[j]) e1 = 1'b0;
          else e0 = 1'b0;
        end
        if (sl0_o !== e0 || sl1_o !== e1) badLine++;
        if (busy !== 1'b1 || tx_ready !== 1'b0) badBusy++;
        if (done !== 1'b0 || bq_err !== 1'b0) badPulse++;
      end else begin
        checkOutput({name, "_done"}, longint'(done), 1);
        checkOutput({name, "_ready_at_done"}, longint'(tx_ready), 1);
        checkOutput({name, "_busy_at_done"}, longint'(busy), 0);
        checkOutput({name, "_lines_at_done"}, longint'({sl0_o, sl1_o}), 3);
      end
    end
    checkOutput({name, "_line_bad_cycles"}, badLine, 0);
    checkOutput({name, "_busy_bad_cycles"}, badBusy, 0);
    checkOutput({name, "_early_pulse_cycles"}, badPulse, 0);
  endtask

  // Illegal bit quantity: one bq_err cycle, nothing on the lines, stays ready.
  task automatic watchErr(input string name);
    int bad;
    bad = 0;
    @(negedge clk);
    checkOutput({name, "_bq_err"}, longint'(bq_err), 1);
    checkOutput({name, "_ready"}, longint'(tx_ready), 1);
    checkOutput({name, "_busy"}, longint'(busy), 0);
    checkOutput({name, "_lines"}, longint'({sl0_o, sl1_o}), 3);
    for (int c = 2; c <= 40; c++) begin
      @(negedge clk);
      if (bq_err !== 1'b0 || done !== 1'b0 || tx_ready !== 1'b1 || sl0_o !== 1'b1 || sl1_o !== 1'b1)
        bad++;
    end
    checkOutput({name, "_quiet_after"}, bad, 0);
  endtask

  initial begin
    int bad;
    vecs[0] = mkVec("a5_n8",      32'h000000A5, 6'd8,  1'b0, 33'h0_000000A5, 8,  1'b0);
    vecs[1] = mkVec("a5_n8_par",  32'h000000A5, 6'd8,  1'b1, 33'h0_000001A5, 9,  1'b0);
    vecs[2] = mkVec("ones_n32",   32'hFFFFFFFF, 6'd32, 1'b1, 33'h1_FFFFFFFF, 33, 1'b0);
    vecs[3] = mkVec("bq0_err",    32'h00000055, 6'd0,  1'b0, 33'h0,          0,  1'b1);
    vecs[4] = mkVec("bq40_err",   32'h12345678, 6'd40, 1'b1, 33'h0,          0,  1'b1);
    vecs[5] = mkVec("n2_par",     32'h00000003, 6'd2,  1'b1, 33'h0_00000007, 3,  1'b0);
    vecs[6] = mkVec("mask_n4",    32'h000000F0, 6'd4,  1'b1, 33'h0_00000010, 5,  1'b0);
    vecs[7] = mkVec("n1_lsb",     32'h80000001, 6'd1,  1'b0, 33'h0_00000001, 1,  1'b0);

    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 32'd0;
    tx_bq = 6'd0;
    tx_pce = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", longint'(tx_ready), 1);
    checkOutput("reset_lines", longint'({sl0_o, sl1_o}), 3);
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_done", longint'(done), 0);
    checkOutput("reset_bq_err", longint'(bq_err), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], 1'b0);
      if (vecs[i].isErr) watchErr(vecs[i].name);
      else watchWord(vecs[i].name, vecs[i].frame, vecs[i].nbits);
    end

    // Back-to-back: valid held, second word accepted at the end of the done cycle.
    applyStimulus(vecs[0], 1'b1);
    tx_data = 32'h000000F0;
    tx_bq   = 6'd4;
    tx_pce  = 1'b1;
    watchWord("b2b_first", vecs[0].frame, 8);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    watchWord("b2b_second", 33'h0_00000010, 5);

    // Reset during bit 3 (a '0', so SL0 low) abandons the word.
    applyStimulus(vecs[0], 1'b0);
    repeat (100) @(negedge clk);
    checkOutput("rst_mid_bit3_low", longint'({sl0_o, sl1_o}), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_lines", longint'({sl0_o, sl1_o}), 3);
    checkOutput("rst_mid_ready", longint'(tx_ready), 1);
    checkOutput("rst_mid_busy", longint'(busy), 0);
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || sl0_o !== 1'b1 || sl1_o !== 1'b1) bad++;
    end
    checkOutput("rst_mid_no_done", bad, 0);
    applyStimulus(vecs[5], 1'b0);
    watchWord("after_rst", vecs[5].frame, vecs[5].nbits);

    // Reset and valid together: reset wins.
    @(negedge clk);
    rst = 1'b1;
    tx_valid = 1'b1;
    tx_data = 32'h000000A5;
    tx_bq = 6'd8;
    tx_pce = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tx_valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_ready !== 1'b1 || sl0_o !== 1'b1 || sl1_o !== 1'b1) bad++;
    end
    checkOutput("rst_with_valid_idle", bad, 0);

    checkOutput("never_both_low", overlapCycles, 0);
    checkOutput("never_done_and_err", doneErrCycles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
